// File: rtl/simd_exec_sequencer.sv
// Purpose : steps one VEC_LEN-element SIMD instruction through LANES ALU lanes, one beat per cycle,
//           assembles the result vector, updates N/Z flags and resolves the branch decision.
// Latency : accept edge + BEATS RUN cycles, then res_valid; holds the result until res_ready.
// Backpressure: start_ready only in IDLE or in DONE while res_ready is high; result held until
//           res_ready; flush drops the in-flight instruction and blocks new requests that cycle.
//
// Ports:
//   clk, reset (async, active-low), flush (sync abort)
//   start_valid/start_ready, op, set_flags, br_cond, vec_a, vec_b   : request from decode
//   alu_op, alu_a, alu_b -> lane array; alu_result, alu_neg, alu_zero <- lane array
//   res_valid/res_ready, res_vec, take_branch                        : result to writeback
//   flag_n, flag_z : architectural flags; busy : high in RUN or DONE
module simd_exec_sequencer #(
  parameter int REG_SIZE = 16,
  parameter int VEC_LEN  = 8,
  parameter int LANES    = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        start_valid,
  output logic                        start_ready,
  input  logic [2:0]                  op,
  input  logic                        set_flags,
  input  logic [2:0]                  br_cond,
  input  logic [VEC_LEN*REG_SIZE-1:0] vec_a,
  input  logic [VEC_LEN*REG_SIZE-1:0] vec_b,
  output logic [2:0]                  alu_op,
  output logic [LANES*REG_SIZE-1:0]   alu_a,
  output logic [LANES*REG_SIZE-1:0]   alu_b,
  input  logic [LANES*REG_SIZE-1:0]   alu_result,
  input  logic [LANES-1:0]            alu_neg,
  input  logic [LANES-1:0]            alu_zero,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [VEC_LEN*REG_SIZE-1:0] res_vec,
  output logic                        flag_n,
  output logic                        flag_z,
  output logic                        take_branch,
  output logic                        busy
);

  localparam int VW    = VEC_LEN * REG_SIZE;
  localparam int LW    = LANES * REG_SIZE;
  localparam int BEATS = VEC_LEN / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  if ((VEC_LEN % LANES) != 0) begin : g_len_check
    $error("simd_exec_sequencer: VEC_LEN must be a multiple of LANES");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Everything the instruction needs after the accept edge.
  typedef struct packed {
    logic [2:0]    op;
    logic          set_flags;
    logic [2:0]    br_cond;
    logic [VW-1:0] a;
    logic [VW-1:0] b;
  } instr_t;

  state_t          state_q, state_d;
  instr_t          instr_q;
  logic [BW-1:0]   beat_q;
  logic            neg_acc;
  logic            zero_acc;
  logic            accept;
  logic            last_beat;
  logic            branch_dec;
  int              beat_base;

  assign beat_base = int'(beat_q) * LW;
  assign last_beat = (beat_q == LAST_BEAT);
  assign accept    = start_valid & start_ready;

  // Branch decision uses the live flags, so a set_flags instruction
  // resolves against the flags it just wrote.
  always_comb begin
    branch_dec = 1'b0;
    case (instr_q.br_cond)
      3'b100:  branch_dec = ~flag_z;
      3'b010:  branch_dec = flag_z;
      3'b001:  branch_dec = flag_n;
      default: branch_dec = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    start_ready = 1'b0;
    res_valid   = 1'b0;
    take_branch = 1'b0;
    busy        = 1'b0;
    alu_op      = 3'b000;
    alu_a       = '0;
    alu_b       = '0;
    case (state_q)
      S_IDLE: begin
        start_ready = ~flush;
        if (start_valid && !flush) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        busy   = 1'b1;
        alu_op = instr_q.op;
        alu_a  = instr_q.a[beat_base +: LW];
        alu_b  = instr_q.b[beat_base +: LW];
        if (flush) begin
          state_d = S_IDLE;
        end else if (last_beat) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        busy        = 1'b1;
        res_valid   = 1'b1;
        take_branch = branch_dec;
        // Back-to-back: a new request can ride the same edge as the result handshake.
        start_ready = res_ready & ~flush;
        if (flush) begin
          state_d = S_IDLE;
        end else if (res_ready) begin
          state_d = start_valid ? S_RUN : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      instr_q  <= '0;
      beat_q   <= '0;
      neg_acc  <= 1'b0;
      zero_acc <= 1'b0;
      res_vec  <= '0;
      flag_n   <= 1'b0;
      flag_z   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        instr_q.op        <= op;
        instr_q.set_flags <= set_flags;
        instr_q.br_cond   <= br_cond;
        instr_q.a         <= vec_a;
        instr_q.b         <= vec_b;
        beat_q            <= '0;
        neg_acc           <= 1'b0;
        zero_acc          <= 1'b1;
      end else if (state_q == S_RUN && !flush) begin
        res_vec[beat_base +: LW] <= alu_result;
        neg_acc                  <= neg_acc | (|alu_neg);
        zero_acc                 <= zero_acc & (&alu_zero);
        beat_q                   <= beat_q + 1'b1;
        // Final beat's lane flags are folded in directly since the
        // accumulators only see them one edge later.
        if (last_beat && instr_q.set_flags) begin
          flag_n <= neg_acc | (|alu_neg);
          flag_z <= zero_acc & (&alu_zero);
        end
      end
    end
  end

endmodule

// File: doc/simd_exec_sequencer.md
Name: simd_exec_sequencer

Overview:
- Sequences one SIMD vector instruction of VEC_LEN elements through a narrower array of LANES ALUs, one beat of LANES elements per cycle.
- Collects per-lane results into a full result vector.
- Accumulates vector-wide negative (any lane) and zero (all lanes) flags into the architectural N/Z flags.
- Resolves the branch-taken decision for the fetch stage.
- Sits between decode (valid/ready request) and writeback (valid/ready result); drives the ALU lane array directly.

Parameters:
- REG_SIZE, 16, bits per vector element.
- VEC_LEN, 8, elements per architectural vector.
- LANES, 2, physical ALU lanes. VEC_LEN must be a multiple of LANES; an elaboration-time error fires otherwise. BEATS = VEC_LEN/LANES.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort of the in-flight instruction.
- start_valid  in  1  request valid.
- start_ready  out  1  request accepted when high with start_valid.
- op  in  3  ALU operation code, passed unchanged to the lanes.
- set_flags  in  1  instruction updates N/Z.
- br_cond  in  3  100=branch if not zero, 010=branch if zero, 001=branch if negative; any other value = no branch.
- vec_a, vec_b  in  VEC_LEN*REG_SIZE  operands; element i is at bits [i*REG_SIZE +: REG_SIZE].
- alu_op  out  3  to the lane array.
- alu_a, alu_b  out  LANES*REG_SIZE  current beat operands.
- alu_result  in  LANES*REG_SIZE  combinational lane results.
- alu_neg, alu_zero  in  LANES  per-lane flags.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_vec  out  VEC_LEN*REG_SIZE  assembled result.
- flag_n, flag_z  out  1  architectural flags.
- take_branch  out  1  valid while res_valid is high.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - res_vec, res_valid, flag_n, flag_z, take_branch, alu_op, alu_a, alu_b, beat counter and all captured registers clear to 0.
  - start_ready=1 once reset=1.
  - Reset mid-RUN or mid-DONE discards the instruction; no res_valid is produced.
- States are IDLE, RUN and DONE.
- IDLE:
  - start_ready=1; alu_op, alu_a and alu_b are driven to 0.
  - Accept on start_valid&start_ready: capture vec_a, vec_b, op, set_flags and br_cond.
  - Set beat=0, neg_acc=0, zero_acc=1; go to RUN.
- RUN, one beat per cycle:
  - alu_op = captured op.
  - alu_a and alu_b carry elements beat*LANES .. beat*LANES+LANES-1.
  - On each edge, write alu_result into the matching res_vec slice.
  - Update neg_acc |= OR(alu_neg) and zero_acc &= AND(alu_zero).
  - beat increments by 1 each edge.
  - On the edge of the last beat (beat==BEATS-1), go to DONE.
  - RUN lasts exactly BEATS cycles. BEATS=1 is legal (single RUN cycle).
- Flag update:
  - On the RUN-to-DONE edge, if set_flags: flag_n <= neg_acc|OR(alu_neg) and flag_z <= zero_acc&AND(alu_zero), both including the final beat.
  - If set_flags=0, the flags hold.
  - Flags change at no other time except reset.
- DONE:
  - res_valid=1.
  - take_branch is computed combinationally from the held br_cond and the current flag_n/flag_z: 100 gives ~flag_z, 010 gives flag_z, 001 gives flag_n, otherwise 0.
  - res_vec, res_valid and take_branch stay stable until res_ready=1.
  - On res_ready=1: if start_valid, accept the new request on the same edge and go to RUN; otherwise go to IDLE.
  - start_ready = IDLE | (DONE & res_ready).
- Latency: accept edge, then BEATS RUN cycles, then res_valid. Maximum throughput is one instruction per BEATS+1 cycles.
- flush=1 (synchronous):
  - In RUN or DONE: go to IDLE, drop the result, clear res_valid; flags are NOT updated.
  - An RUN-to-DONE edge coinciding with flush is suppressed, including its flag write.
  - flush has priority over accept; start_ready=0 while flush=1.
- res_vec keeps the last written value after leaving DONE. res_vec is only meaningful while res_valid=1.

Test Plan:
Bench setup: REG_SIZE=16, VEC_LEN=8, LANES=2; the bench ALU model implements op 000=add and 001=sub, with neg = result MSB and zero = (result==0).
1. Reset low for 3 cycles, then high: every output is 0 and start_ready=1. The first accept after release is taken on the next edge.
2. op=000, set_flags=1, a=1..8, b=10 in every element: alu_a shows pairs (1,2), (3,4), (5,6), (7,8) on cycles 1-4 after accept. res_valid=1 on cycle 5 with res_vec=11..18, flag_n=0, flag_z=0.
3. op=001, set_flags=1, br_cond=010, a=b=5 in every element: flag_z=1 and take_branch=1. Next instruction with set_flags=0, br_cond=100 and nonzero data: flag_z stays 1 and take_branch=0.
4. op=001, set_flags=1, br_cond=001, a=3 in every element except b[6]=4: res_vec[6]=0xFFFF, flag_n=1, take_branch=1. Also check that a negative result in beat 0 only still gives flag_n=1.
5. Hold res_ready=0 for 3 cycles in DONE: res_vec, res_valid and take_branch stay stable, start_ready=0. Then res_ready=1 with start_valid=1: the new request is accepted the same cycle and RUN begins next cycle with no IDLE gap.
6. Drive reset=0 asynchronously during RUN beat 2: outputs go to 0 immediately and res_valid never asserts. Separately, flush=1 on the last-beat cycle with set_flags=1: no res_valid, prior flags retained, state returns to IDLE.
